// File: rtl/decode_issue_ctrl.sv
// -----------------------------------------------------------------------------
// decode_issue_ctrl
//
// Issue controller between the decode stage's control register and the execute
// stage. Decoded control words {AR, BR, ALU, input, wren} are buffered in a
// 2-entry queue. Both sides use valid/ready handshakes. After a word with wren
// set issues, any head word that reads AR or BR is held for WB_LAT cycles
// (write-back interlock). FLUSH empties the queue and clears the interlock
// synchronously.
//
// Optional feature macro: DECODE_ISSUE_PERF_EN
//   When defined, this adds the CNT_W parameter and the STALL_CNT port. STALL_CNT
//   is a saturating count of cycles in which a queued head was held by the
//   interlock. Only RST clears it.
//
// Parameters:
//   WB_LAT  interlock length in cycles after a wren issue (1..15)
//   CNT_W   width of STALL_CNT (only with DECODE_ISSUE_PERF_EN)
//
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   FLUSH                         synchronous flush of queue and interlock
//   IN_VALID / IN_READY           upstream handshake
//   AR_IN..wren_IN                incoming control word
//   OUT_VALID / OUT_READY         execute-side handshake
//   AR_OUT..wren_OUT              head control word (0 when empty)
//   STALL_CNT                     interlock stall count (perf build only)
// -----------------------------------------------------------------------------
module decode_issue_ctrl #(
  parameter int WB_LAT = 2
`ifdef DECODE_ISSUE_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic CLK,
  input  logic RST,
  input  logic FLUSH,
  input  logic IN_VALID,
  output logic IN_READY,
  input  logic AR_IN,
  input  logic BR_IN,
  input  logic ALU_IN,
  input  logic input_IN,
  input  logic wren_IN,
  output logic OUT_VALID,
  input  logic OUT_READY,
  output logic AR_OUT,
  output logic BR_OUT,
  output logic ALU_OUT,
  output logic input_OUT,
  output logic wren_OUT
`ifdef DECODE_ISSUE_PERF_EN
  , output logic [CNT_W-1:0] STALL_CNT
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [3:0] WB_LAT_L = 4'(WB_LAT);

  state_t     state_reg, state_next;
  logic [4:0] head_reg, head_next;
  logic [4:0] tail_reg, tail_next;
  logic [3:0] ilk_reg, ilk_next;

  logic [4:0] in_word;
  logic [4:0] head_word;
  logic       blocked;
  logic       push;
  logic       pop;

  // Word layout: [4]=AR [3]=BR [2]=ALU [1]=input [0]=wren
  assign in_word   = {AR_IN, BR_IN, ALU_IN, input_IN, wren_IN};
  // The head register may hold a stale word while empty, so mask it here.
  assign head_word = (state_reg != EMPTY) ? head_reg : 5'd0;

  // Only AR/BR readers depend on the pending write-back.
  assign blocked   = (ilk_reg != 4'd0) && (head_word[4] || head_word[3]);

  assign IN_READY  = (state_reg != FULL) && !FLUSH;
  assign OUT_VALID = (state_reg != EMPTY) && !blocked && !FLUSH;
  assign push      = IN_VALID && IN_READY;
  assign pop       = OUT_VALID && OUT_READY;

  assign {AR_OUT, BR_OUT, ALU_OUT, input_OUT, wren_OUT} = head_word;

  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    ilk_next   = ilk_reg;

    if (ilk_reg != 4'd0) begin
      ilk_next = ilk_reg - 4'd1;
    end
    // A wren issue restarts the window, which overrides the decrement.
    if (pop && head_word[0]) begin
      ilk_next = WB_LAT_L;
    end

    case (state_reg)
      EMPTY: begin
        if (push) begin
          head_next  = in_word;
          state_next = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          // The old head leaves, so the incoming word takes its place.
          head_next = in_word;
        end else if (push) begin
          tail_next  = in_word;
          state_next = FULL;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        // IN_READY is low in FULL, so only a pop can happen.
        if (pop) begin
          head_next  = tail_reg;
          state_next = ONE;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase

    // The handshakes are already suppressed during FLUSH. This branch only clears
    // the occupancy and the interlock.
    if (FLUSH) begin
      state_next = EMPTY;
      ilk_next   = 4'd0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= EMPTY;
      head_reg  <= 5'd0;
      tail_reg  <= 5'd0;
      ilk_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      ilk_reg   <= ilk_next;
    end
  end

`ifdef DECODE_ISSUE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic             stall_inc;

  assign stall_inc = (state_reg != EMPTY) && blocked && !FLUSH;

  // Saturating counter. FLUSH does not clear it, so it accumulates across flushes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_reg <= '0;
    end else if (stall_inc && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign STALL_CNT = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
module tb_decode_issue_ctrl;
  localparam int WB_LAT = 2;

  // Word layout: {AR, BR, ALU, input, wren}
  localparam logic [4:0] W_AR   = 5'b10000;
  localparam logic [4:0] W_BR   = 5'b01000;
  localparam logic [4:0] W_ALU  = 5'b00100;
  localparam logic [4:0] W_WREN = 5'b00001;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic FLUSH = 1'b0;
  logic IN_VALID = 1'b0;
  logic IN_READY;
  logic AR_IN = 1'b0, BR_IN = 1'b0, ALU_IN = 1'b0, input_IN = 1'b0, wren_IN = 1'b0;
  logic OUT_VALID;
  logic OUT_READY = 1'b0;
  logic AR_OUT, BR_OUT, ALU_OUT, input_OUT, wren_OUT;
`ifdef DECODE_ISSUE_PERF_EN
  logic [15:0] STALL_CNT;
`endif

  always #5 CLK = ~CLK;

  decode_issue_ctrl #(.WB_LAT(WB_LAT)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .AR_IN(AR_IN), .BR_IN(BR_IN), .ALU_IN(ALU_IN), .input_IN(input_IN), .wren_IN(wren_IN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .AR_OUT(AR_OUT), .BR_OUT(BR_OUT), .ALU_OUT(ALU_OUT), .input_OUT(input_OUT), .wren_OUT(wren_OUT)
`ifdef DECODE_ISSUE_PERF_EN
    , .STALL_CNT(STALL_CNT)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: an ordered list of queued words, plus the cycle of the
  // most recent wren issue. A reader is held while cyc - last_wren <= WB_LAT.
  logic [4:0] q[$];
  int last_wren = -1000;
  int stall_model = 0;
  int dut_pop_cyc = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance.
  task automatic step(input logic iv, input logic [4:0] w, input logic ordy, input logic fl);
    logic [4:0] hd;
    logic blk, exp_ir, exp_ov, push, pop;
    IN_VALID = iv;
    {AR_IN, BR_IN, ALU_IN, input_IN, wren_IN} = w;
    OUT_READY = ordy;
    FLUSH = fl;
    #1;
    hd = (q.size() > 0) ? q[0] : 5'd0;
    blk = (q.size() > 0) && (hd[4] || hd[3]) && ((cyc - last_wren) <= WB_LAT);
    exp_ir = (q.size() < 2) && !fl;
    exp_ov = (q.size() > 0) && !blk && !fl;
    chk("in_ready", 32'(IN_READY), 32'(exp_ir));
    chk("out_valid", 32'(OUT_VALID), 32'(exp_ov));
    chk("out_word", 32'({AR_OUT, BR_OUT, ALU_OUT, input_OUT, wren_OUT}), 32'(hd));
`ifdef DECODE_ISSUE_PERF_EN
    chk("stall_cnt", 32'(STALL_CNT), 32'(stall_model));
`endif
    if (OUT_VALID && ordy) dut_pop_cyc = cyc;
    push = iv && exp_ir;
    pop = exp_ov && ordy;
    if (push || pop || fl)
      $display("cyc=%0d push=%b in=%05b pop=%b head=%05b flush=%b", cyc, push, w, pop, hd, fl);
    if (fl) begin
      q.delete();
      last_wren = -1000;
    end else begin
      if (blk) stall_model++;
      if (pop) begin
        if (hd[0]) last_wren = cyc;
        void'(q.pop_front());
      end
      if (push) q.push_back(w);
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 1'b1, 1'b0);
  endtask

  initial begin
    int c;
    int s0;
    // Reset state
    #12;
    chk("rst_in_ready", 32'(IN_READY), 32'd1);
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_word", 32'({AR_OUT, BR_OUT, ALU_OUT, input_OUT, wren_OUT}), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Fill/drain: the third word is held until the first pop frees a slot.
    step(1'b1, 5'b00110, 1'b0, 1'b0);
    step(1'b1, 5'b00100, 1'b0, 1'b0);
    step(1'b1, 5'b00010, 1'b0, 1'b0);
    step(1'b1, 5'b00010, 1'b1, 1'b0);
    step(1'b1, 5'b00010, 1'b1, 1'b0);
    step(1'b0, 5'd0, 1'b1, 1'b0);
    chk("drain_empty", 32'(OUT_VALID), 32'd0);

    // Streaming: 10 independent words
    for (int i = 0; i < 10; i++) step(1'b1, {3'b001, 1'(i), 1'b0}, 1'b1, 1'b0);
    idle(1);

    // Interlock: an AR reader follows a wren word.
`ifdef DECODE_ISSUE_PERF_EN
    s0 = int'(STALL_CNT);
`else
    s0 = 0;
`endif
    step(1'b1, W_WREN, 1'b0, 1'b0);
    c = cyc;
    step(1'b1, W_AR, 1'b1, 1'b0);
    idle(3);
    chk("dep_issue_cyc", 32'(dut_pop_cyc), 32'(c + 3));
`ifdef DECODE_ISSUE_PERF_EN
    chk("ilk_stall_delta", 32'(int'(STALL_CNT) - s0), 32'd2);
`endif

    // Non-reader follower is never held.
    step(1'b1, W_WREN, 1'b0, 1'b0);
    c = cyc;
    step(1'b1, W_ALU, 1'b1, 1'b0);
    step(1'b0, 5'd0, 1'b1, 1'b0);
    chk("alu_issue_cyc", 32'(dut_pop_cyc), 32'(c + 1));
    idle(3);

    // Reload: back-to-back wren issues extend the window.
    step(1'b1, W_WREN, 1'b0, 1'b0);
    c = cyc;
    step(1'b1, W_WREN, 1'b1, 1'b0);
    step(1'b1, W_BR, 1'b1, 1'b0);
    idle(4);
    chk("reload_issue_cyc", 32'(dut_pop_cyc), 32'(c + 4));

    // Flush: FULL with one interlock cycle left
    step(1'b1, W_WREN, 1'b0, 1'b0);
    step(1'b1, W_AR, 1'b1, 1'b0);
    step(1'b1, W_AR | W_ALU, 1'b1, 1'b0);
    step(1'b0, 5'd0, 1'b1, 1'b1);
    c = cyc;
    step(1'b1, W_AR, 1'b1, 1'b0);
    step(1'b0, 5'd0, 1'b1, 1'b0);
    chk("post_flush_issue_cyc", 32'(dut_pop_cyc), 32'(c + 1));

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 15) == 0));
    idle(4);

    // Asynchronous reset while FULL and blocked
    step(1'b1, W_WREN, 1'b0, 1'b0);
    step(1'b1, W_AR, 1'b1, 1'b0);
    step(1'b1, W_BR, 1'b1, 1'b0);
    IN_VALID = 1'b0;
    RST = 1'b1;
    #1;
    chk("arst_in_ready", 32'(IN_READY), 32'd1);
    chk("arst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("arst_word", 32'({AR_OUT, BR_OUT, ALU_OUT, input_OUT, wren_OUT}), 32'd0);
`ifdef DECODE_ISSUE_PERF_EN
    chk("arst_stall", 32'(STALL_CNT), 32'd0);
`endif
    q.delete();
    last_wren = -1000;
    stall_model = 0;
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    cyc++;
    step(1'b1, W_AR, 1'b1, 1'b0);
    step(1'b0, 5'd0, 1'b1, 1'b0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_issue_ctrl.md
# decode_issue_ctrl

Issue controller between the decode stage's one-word control register and the execute stage. Buffers decoded control words (AR, BR, ALU, input, wren bits) in a 2-entry queue with valid/ready handshakes on both sides. Enforces a write-back interlock: after a word with wren set issues, any word that reads AR or BR is held for a fixed number of cycles. Supports a synchronous pipeline flush.

## Interface
- WB_LAT, default 2: interlock length in cycles after a wren issue; legal range 1..15.
- CNT_W, default 16: width of STALL_CNT.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- FLUSH  in  1  synchronous flush of the queue and interlock.
- IN_VALID  in  1  upstream word valid.
- IN_READY  out  1  queue can accept a word.
- AR_IN, BR_IN, ALU_IN, input_IN, wren_IN  in  1 each  incoming control word.
- OUT_VALID  out  1  head word is issuable.
- OUT_READY  in  1  execute stage accepts.
- AR_OUT, BR_OUT, ALU_OUT, input_OUT, wren_OUT  out  1 each  head control word.
- STALL_CNT  out  CNT_W  interlock stall count; present only with DECODE_ISSUE_PERF_EN.

## Operation
- **Queue.**
  - 2-entry FIFO, 5-bit entries.
  - Occupancy state: EMPTY (0), ONE (1), FULL (2).
- **Push.**
  - Push when IN_VALID && IN_READY.
  - IN_READY = (state != FULL) && !FLUSH.
- **Pop.**
  - Pop (issue) when OUT_VALID && OUT_READY.
  - OUT_VALID = (state != EMPTY) && !blocked && !FLUSH.
- **State transitions.**
  - EMPTY + push → ONE.
  - ONE + push, no pop → FULL.
  - ONE + pop, no push → EMPTY.
  - ONE + push + pop → ONE; the new word becomes the head.
  - FULL + pop → ONE. No push is possible in FULL.
- **Output fields.**
  - *_OUT show the head entry whenever state != EMPTY, even while blocked.
  - All *_OUT are 0 when EMPTY.
- **Interlock.**
  - 4-bit counter `ilk`.
  - On an issue with wren_OUT=1, `ilk` loads WB_LAT. This overrides any decrement in the same cycle.
  - Otherwise `ilk` decrements by 1 while non-zero.
  - blocked = (ilk != 0) && (AR_OUT || BR_OUT).
  - A head with AR=BR=0 is never blocked.
  - The interlock does not reorder words; a blocked head blocks the entry behind it.
- **Flush.**
  - In a FLUSH cycle, handshakes on both sides are suppressed.
  - Next cycle: state = EMPTY, ilk = 0.
  - FLUSH has priority over push, pop and ilk load.
- **Reset (RST high, asynchronous).**
  - state = EMPTY, ilk = 0, STALL_CNT = 0.
  - Output values: IN_READY = 1, OUT_VALID = 0, all *_OUT = 0.

## Timing
- Latency: a word pushed at edge t is on *_OUT with OUT_VALID=1 after edge t. Minimum pass-through latency is 1 cycle.
- Throughput: 1 word/cycle sustained while OUT_READY=1 and no interlock.
- Interlock example, WB_LAT=2: wren word issues in cycle c.
  - ilk = 2 in cycle c+1, 1 in cycle c+2.
  - A dependent head can issue no earlier than cycle c+3.
- Back-to-back wren issues: each issue reloads ilk, so the window extends from the last wren issue.
- Upstream may hold IN_VALID with stable data while IN_READY=0; no word is lost or duplicated.
- RST deassertion takes effect at the next rising edge; no handshake occurs in that cycle's prior state.
- FLUSH asserted mid-interlock clears ilk. A word pushed in the cycle after FLUSH is immediately issuable.

## Configuration
- **DECODE_ISSUE_PERF_EN defined:**
  - STALL_CNT port and counter exist.
  - The counter increments each cycle in which state != EMPTY, blocked=1 and FLUSH=0.
  - It saturates at all-ones.
  - It is cleared only by RST; FLUSH does not clear it.
- **DECODE_ISSUE_PERF_EN undefined:**
  - STALL_CNT port and counter are absent.
  - All other behaviour is identical.

## Test plan
- **Fill/drain:**
  - Push 3 words with OUT_READY=0 → IN_READY drops after the 2nd push and the 3rd is held.
  - Raise OUT_READY → words issue in order, one per cycle; the 3rd is accepted the cycle after the first pop.
- **Streaming:**
  - IN_VALID=OUT_READY=1 for 10 words with AR=BR=wren=0 → 10 issues in 10 consecutive cycles after a 1-cycle fill; state stays ONE.
- **Interlock, WB_LAT=2:**
  - Issue {wren=1} at cycle c, followed by {AR=1} → OUT_VALID=0 in cycles c+1 and c+2, issue at c+3.
  - STALL_CNT=2 with PERF_EN.
  - Repeat with follower {ALU=1, AR=BR=0} → issues at c+1.
- **Reload:**
  - wren issues at c and c+1, then {BR=1} → dependent issues at c+4.
- **Flush:**
  - FULL queue with ilk=1, assert FLUSH for 1 cycle → OUT_VALID=0 and IN_READY=0 that cycle.
  - Next cycle: EMPTY, ilk=0. A push of {AR=1} then issues 1 cycle later.
- **Reset mid-operation:**
  - Assert RST asynchronously while FULL and blocked → outputs immediately IN_READY=1, OUT_VALID=0, *_OUT=0, STALL_CNT=0.
